// File: rtl/accumulator_drain_pkg.sv
// Shared widths, FSM encoding and the lane requantizer used by the drain and its reference model.
package accumulator_drain_pkg;

  function automatic int psum_width(input int w, input int a, input int s);
    return w + a + $clog2(s);
  endfunction

  function automatic int addr_width(input int p, input int s);
    return $clog2(p * s);
  endfunction

  localparam int SYSTOLIC_SIZE     = 8;
  localparam int WEIGHT_WIDTH      = 8;
  localparam int ACTIVATION_WIDTH  = 8;
  localparam int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE);
  localparam int PATTERN_NUMBER    = 1;
  localparam int ADDR_WIDTH        = addr_width(PATTERN_NUMBER, SYSTOLIC_SIZE);
  localparam int RD_LATENCY        = 1;
  localparam int FIFO_DEPTH        = 4;
  localparam int SHIFT_WIDTH       = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [PARTIAL_SUM_WIDTH:0] SAT_MAX =
    (PARTIAL_SUM_WIDTH+1)'(2**(ACTIVATION_WIDTH-1) - 1);
  localparam logic signed [PARTIAL_SUM_WIDTH:0] SAT_MIN =
    (PARTIAL_SUM_WIDTH+1)'(-(2**(ACTIVATION_WIDTH-1)));

  // One extra bit of headroom so the rounding bias cannot overflow the lane.
  function automatic logic [ACTIVATION_WIDTH-1:0] requantize(
    input logic [PARTIAL_SUM_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]       s,
    input logic                         relu
  );
    logic signed [PARTIAL_SUM_WIDTH:0] ext;
    logic signed [PARTIAL_SUM_WIDTH:0] bias;
    logic signed [PARTIAL_SUM_WIDTH:0] r;
    ext  = {x[PARTIAL_SUM_WIDTH-1], x};
    bias = '0;
    if (s >= SHIFT_WIDTH'(PARTIAL_SUM_WIDTH)) begin
      r = x[PARTIAL_SUM_WIDTH-1] ? '1 : '0;
    end else begin
      if (s != '0) bias[s - SHIFT_WIDTH'(1)] = 1'b1;
      r = (ext + bias) >>> s;
    end
    if (relu && r[PARTIAL_SUM_WIDTH]) r = '0;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[ACTIVATION_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/accumulator_drain_if.sv
// Row stream from the drain towards the activation buffer / next layer.
interface accumulator_drain_if
  import accumulator_drain_pkg::*;
();
  logic                                    out_valid;
  logic                                    out_ready;
  logic [ACTIVATION_WIDTH*SYSTOLIC_SIZE-1:0] out_data;
  logic                                    out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/accumulator_drain_fifo.sv
// Small show-ahead FIFO holding quantized rows plus their last flag.
module drain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_en) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is forced to zero when empty so the stream idles at all-zero.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
endmodule

// File: rtl/accumulator_drain.sv
// Reads accumulated rows, requantizes each lane and streams one row per beat.
module accumulator_drain
  import accumulator_drain_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [ADDR_WIDTH:0]                         num_rows,
  input  logic [SHIFT_WIDTH-1:0]                      shift_amt,
  input  logic                                        relu_en,
  output logic [ADDR_WIDTH-1:0]                       rd_addr,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]  partial_sum_outputs_flat,
  accumulator_drain_if.master                         out_if,
  output logic                                        busy,
  output logic                                        done
);
  localparam int ROW_W    = ACTIVATION_WIDTH * SYSTOLIC_SIZE;
  localparam int CNT_W    = $clog2(FIFO_DEPTH+1);
  localparam int FLIGHT_W = $clog2(RD_LATENCY+2);
  localparam int SUM_W    = CNT_W + FLIGHT_W;
  localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH+1)'(PATTERN_NUMBER*SYSTOLIC_SIZE);

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH:0]    rows_eff_reg, issue_cnt_reg;
  logic [SHIFT_WIDTH-1:0] shift_reg;
  logic                   relu_reg;
  logic [ADDR_WIDTH-1:0]  rd_addr_reg;
  logic [RD_LATENCY:0]    valid_pipe_reg, last_pipe_reg;

  logic [ADDR_WIDTH:0]    start_rows, issue_idx, rows_cur;
  logic                   issue, issue_last;
  logic [FLIGHT_W-1:0]    in_flight;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [ROW_W-1:0]       quant_row;
  logic [ROW_W:0]         fifo_head;

  assign start_rows = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;

  // Reads in flight include the cycle the address sits on the bus.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) in_flight = in_flight + FLIGHT_W'(valid_pipe_reg[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    issue_idx  = issue_cnt_reg;
    rows_cur   = rows_eff_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        issue_idx = '0;
        rows_cur  = start_rows;
        if (start) begin
          issue      = (num_rows != '0);
          state_next = (num_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = (issue_cnt_reg < rows_eff_reg) &&
                ((SUM_W'(fifo_count) + SUM_W'(in_flight)) < SUM_W'(FIFO_DEPTH));
        if (out_if.out_valid && out_if.out_ready && out_if.out_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign issue_last = (issue_idx == rows_cur - (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_eff_reg   <= '0;
      shift_reg      <= '0;
      relu_reg       <= 1'b0;
      issue_cnt_reg  <= '0;
      rd_addr_reg    <= '0;
      valid_pipe_reg <= '0;
      last_pipe_reg  <= '0;
    end else begin
      valid_pipe_reg <= {valid_pipe_reg[RD_LATENCY-1:0], issue};
      last_pipe_reg  <= {last_pipe_reg[RD_LATENCY-1:0], issue & issue_last};
      if (issue) begin
        rd_addr_reg   <= issue_idx[ADDR_WIDTH-1:0];
        issue_cnt_reg <= issue_idx + (ADDR_WIDTH+1)'(1);
      end
      if (state_reg == IDLE && start) begin
        rows_eff_reg <= start_rows;
        shift_reg    <= shift_amt;
        relu_reg     <= relu_en;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_lane
      assign quant_row[gi*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
        requantize(partial_sum_outputs_flat[gi*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH],
                   shift_reg, relu_reg);
    end
  endgenerate

  assign fifo_wr = valid_pipe_reg[RD_LATENCY];
  assign fifo_rd = out_if.out_valid && out_if.out_ready;

  drain_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ROW_W+1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({last_pipe_reg[RD_LATENCY], quant_row}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full && !fifo_rd));

  assign rd_addr          = rd_addr_reg;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_head[ROW_W-1:0];
  assign out_if.out_last  = fifo_head[ROW_W];
endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench: accumulator read model, drain scenarios, backpressure and reset abort.
module tb_accumulator_drain;
  import accumulator_drain_pkg::*;

  localparam int PSW   = PARTIAL_SUM_WIDTH;
  localparam int ROW_W = ACTIVATION_WIDTH * SYSTOLIC_SIZE;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [ADDR_WIDTH:0]          num_rows = '0;
  logic [SHIFT_WIDTH-1:0]       shift_amt = '0;
  logic                         relu_en = 1'b0;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [PSW*SYSTOLIC_SIZE-1:0] psum_flat = '0;
  logic                         busy, done;

  int checks = 0;
  int failures = 0;
  int mem_lane [8][8];
  logic [ROW_W-1:0] exp_q [16];

  accumulator_drain_if out_if();

  accumulator_drain dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .num_rows                 (num_rows),
    .shift_amt                (shift_amt),
    .relu_en                  (relu_en),
    .rd_addr                  (rd_addr),
    .partial_sum_outputs_flat (psum_flat),
    .out_if                   (out_if),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [PSW*8-1:0] row_flat(input logic [2:0] a);
    logic [PSW*8-1:0] r;
    int v;
    for (int i = 0; i < 8; i++) begin
      v = mem_lane[a][i];
      r[i*PSW +: PSW] = v[PSW-1:0];
    end
    return r;
  endfunction

  // Accumulator memory with one cycle registered read.
  always @(posedge clk) psum_flat <= row_flat(rd_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_row0(input int l0, input int l1, input int l2, input int l3);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++) mem_lane[k][i] = 0;
    mem_lane[0][0] = l0;
    mem_lane[0][1] = l1;
    mem_lane[0][2] = l2;
    mem_lane[0][3] = l3;
  endtask

  task automatic drain(input string tag, input logic [ADDR_WIDTH:0] n, input logic [SHIFT_WIDTH-1:0] sh,
                       input logic rl, input int exp_beats, input int exp_first, input int exp_done,
                       input int stall_at, input int start_at);
    int beat, cyc, first_cyc, done_cyc;
    bit busy_ok, stable_ok, stalled, pulsed;
    logic [ROW_W-1:0] held;
    logic held_last;
    beat = 0; cyc = 0; first_cyc = -1; done_cyc = -1;
    busy_ok = 1; stalled = 0; pulsed = 0;
    num_rows = n; shift_amt = sh; relu_en = rl; out_if.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
      end else begin
        busy_ok &= busy;
        if (out_if.out_valid && first_cyc < 0) first_cyc = cyc;
        if (beat == start_at && !pulsed) begin
          start = 1'b1;
          num_rows = 1;
          pulsed = 1;
        end
        if (beat == stall_at && out_if.out_valid && !stalled) begin
          stalled = 1;
          out_if.out_ready = 1'b0;
          held = out_if.out_data;
          held_last = out_if.out_last;
          stable_ok = 1;
          repeat (10) begin
            tick();
            cyc++;
            start = 1'b0;
            stable_ok &= out_if.out_valid && (out_if.out_data === held) && (out_if.out_last === held_last);
          end
          check({tag, "_stall_hold"}, stable_ok, 1);
          check({tag, "_readahead"}, rd_addr, stall_at + FIFO_DEPTH - 1);
          out_if.out_ready = 1'b1;
        end
        if (out_if.out_valid && out_if.out_ready && beat < 16) begin
          check($sformatf("%s_data%0d", tag, beat), out_if.out_data, exp_q[beat]);
          check($sformatf("%s_last%0d", tag, beat), out_if.out_last, beat == exp_beats - 1);
          beat++;
        end
      end
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, done_cyc >= 0, 1);
    check({tag, "_beats"}, beat, exp_beats);
    check({tag, "_busy"}, busy_ok, 1);
    if (exp_first >= 0) check({tag, "_first_valid_cyc"}, first_cyc, exp_first);
    if (exp_done >= 0) check({tag, "_done_cyc"}, done_cyc, exp_done);
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int beat, cyc;
    bit seen;
    logic [ROW_W-1:0] tmp;
    out_if.out_ready = 1'b1;
    set_row0(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_data", out_if.out_data, 0);
    check("rst_ctrl", {rd_addr, out_if.out_valid, out_if.out_last, busy, done}, 0);
    rst_n = 1'b1;
    tick();

    set_row0(5, -3, 0, 0);
    exp_q[0] = 64'h0000_0000_0000_FD05;
    drain("pass", 1, 0, 0, 1, 2, 3, -1, -1);

    set_row0(300, -300, 23, -23);
    exp_q[0] = 64'h0000_0000_E917_807F;
    drain("sat", 1, 0, 0, 1, 2, 3, -1, -1);
    exp_q[0] = 64'h0000_0000_FA06_B54B;
    drain("round", 1, 2, 0, 1, 2, 3, -1, -1);
    exp_q[0] = 64'h0000_0000_0006_004B;
    drain("relu", 1, 2, 1, 1, 2, 3, -1, -1);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        mem_lane[k][i] = k * 8 + i;
        tmp[i*8 +: 8] = 8'(k * 8 + i);
      end
      exp_q[k] = tmp;
    end
    drain("full", 8, 0, 0, 8, 2, 10, -1, -1);
    drain("bp", 8, 0, 0, 8, 2, -1, 2, -1);
    drain("zero", 0, 0, 0, 0, -1, 0, -1, -1);
    drain("clamp", 15, 0, 0, 8, 2, 10, -1, 1);

    num_rows = 8; shift_amt = 0; relu_en = 0; start = 1'b1;
    tick();
    start = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 100) begin
      if (out_if.out_valid && out_if.out_ready) beat++;
      tick();
      cyc++;
    end
    check("mr_beats", beat, 4);
    rst_n = 1'b0;
    #1;
    check("mr_data", out_if.out_data, 0);
    check("mr_ctrl", {rd_addr, out_if.out_valid, out_if.out_last, busy, done}, 0);
    seen = 0;
    repeat (3) begin
      tick();
      seen |= done | out_if.out_valid;
    end
    check("mr_quiet", seen, 0);
    rst_n = 1'b1;
    tick();
    drain("after_rst", 8, 0, 0, 8, 2, 10, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accumulator_drain.md
Name: accumulator_drain

Overview:
- Downstream consumer of the accumulator bank.
- After a tile has been accumulated, reads result rows out of the accumulator memories by driving the accumulator's outside read address.
- Requantizes each PARTIAL_SUM_WIDTH lane to ACTIVATION_WIDTH (rounding shift, optional ReLU, saturation).
- Streams one row per beat on a valid/ready interface towards the activation buffer or the next layer.

Parameters:
- SYSTOLIC_SIZE, 8, lanes per row.
- WEIGHT_WIDTH, 8, weight width.
- ACTIVATION_WIDTH, 8, output lane width (signed).
- PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE), input lane width (signed two's complement).
- PATTERN_NUMBER, 1, patterns stored per accumulator.
- ADDR_WIDTH, $clog2(PATTERN_NUMBER*SYSTOLIC_SIZE), accumulator row address width.
- RD_LATENCY, 1, cycles from rd_addr to valid partial_sum_outputs_flat.
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1.
- SHIFT_WIDTH, 5, width of shift_amt.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin drain; sampled only in IDLE
- num_rows  input  ADDR_WIDTH+1  rows to drain, latched at start
- shift_amt  input  SHIFT_WIDTH  arithmetic right shift, latched at start
- relu_en  input  1  clamp negatives to 0, latched at start
- rd_addr  output  ADDR_WIDTH  to accumulator rd_addr_outside
- partial_sum_outputs_flat  input  PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE  accumulator read data
- out_valid  output  1  row available
- out_ready  input  1  consumer accepts row
- out_data  output  ACTIVATION_WIDTH*SYSTOLIC_SIZE  quantized row; lane i at [i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]
- out_last  output  1  qualifies final row of the drain
- busy  output  1  drain in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. The FSM goes to IDLE, the FIFO empties and all counters clear. Reset mid-drain aborts the drain: no further beats and no done pulse.
- FSM states:
  - IDLE: start=1 latches config. If num_rows=0, go to DONE. Otherwise go to RUN with issue_cnt=0.
  - RUN: each cycle with issue_cnt < rows_eff and (fifo_count + in_flight) < FIFO_DEPTH, issue a read: rd_addr<=issue_cnt, issue_cnt++. Go to DONE on the handshake of the beat with out_last=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- rows_eff = min(num_rows, PATTERN_NUMBER*SYSTOLIC_SIZE). Addresses never wrap.
- busy: high in RUN and DONE.
- start: ignored outside IDLE.
- Read return: an RD_LATENCY-deep valid shift register tracks issued reads. The returned row is requantized combinationally and written to the FIFO in the same cycle. The credit check guarantees the FIFO never overflows; a write while full is an assertion failure.
- Latency: start at cycle 0 → rd_addr=0 at cycle 1 → data at cycle 1+RD_LATENCY → out_valid at cycle 2+RD_LATENCY. Steady-state throughput is 1 row/cycle with out_ready=1.
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer.
  - Simultaneous FIFO write and read is allowed when full-minus-pop permits.
- out_last: 1 on beat number rows_eff-1 (0-based).
- Requantization, per lane, with s = shift_amt:
  - Rounding: r = (x + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in PARTIAL_SUM_WIDTH+1 bits to avoid overflow.
  - shift_amt >= PARTIAL_SUM_WIDTH yields 0 or -1.
  - ReLU: if relu_en and r<0, then r=0.
  - Saturation: to [-2^(A-1), 2^(A-1)-1], with A = ACTIVATION_WIDTH.

Decomposition:
- Shared package:
  - PARTIAL_SUM_WIDTH and ADDR_WIDTH derivation functions.
  - FSM state enum (IDLE/RUN/DONE).
  - Requantize function (round, relu, saturate), reused by the golden model.
- Sub-module drain_fifo: synchronous FIFO of FIFO_DEPTH × (ACTIVATION_WIDTH*SYSTOLIC_SIZE+1) bits, carrying data plus last. It exposes count/full/empty and pairs with the same clk/rst_n.

Test Plan:
- Pass-through: mem row0 lanes {5,-3,0,…}, num_rows=1, shift=0, relu=0 → one beat lanes {0x05,0xFD,0x00}, out_last=1, out_valid at cycle 3 after start (RD_LATENCY=1), done 1 cycle after handshake.
- Saturation/rounding: lanes {300,-300,23,-23}, shift=0 → {127,-128,…}. Same lanes with shift=2 → {75,-75,6,-6}. With relu=1 → {75,0,6,0}.
- Full drain with out_ready=1: num_rows=8, row k lane i = k*8+i → 8 consecutive beats in address order, out_last only on beat 7, busy high throughout.
- Backpressure: out_ready=0 for 10 cycles mid-drain → at most FIFO_DEPTH rows read ahead, out_data stable, no loss or reordering after release.
- Boundaries: num_rows=0 → no beat, done on the cycle after start. num_rows=15 → clamped to 8 beats. start pulsed while busy → ignored.
- Reset mid-drain: rst_n low after beat 3 → all outputs 0 immediately. A new start then drains from row 0 correctly.
